// File: rtl/core_step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Ports: clk, reset_n; run, halt_req, should_* decoder controls, alu_result,
//   pc_next, mem_ready in; mem_req/mem_we/mem_addr, instr_we, reg_we,
//   xmm_we, pc, state, halted, retire_count out.
module core_step_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        halt_req,
  input  logic        should_read_mem,
  input  logic        should_write_mem,
  input  logic        should_write_reg,
  input  logic        should_write_xmm,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_next,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic        instr_we,
  output logic        reg_we,
  output logic        xmm_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retire_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        halted_q, halted_d;

  logic        req_c;
  logic        we_c;
  logic        iwe_c;
  logic        rwe_c;
  logic        xwe_c;
  logic [31:0] addr_c;
  logic        mem_op;

  assign mem_op = should_read_mem | should_write_mem;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retire_cnt_d = retire_cnt_q;
    halted_d     = halted_q;
    req_c        = 1'b0;
    we_c         = 1'b0;
    iwe_c        = 1'b0;
    rwe_c        = 1'b0;
    xwe_c        = 1'b0;
    addr_c       = pc_q;
    case (state_q)
      S_FETCH: begin
        req_c = run;
        if (run && mem_ready) begin
          iwe_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = mem_op ? S_MEM : S_WB;
      S_MEM: begin
        req_c  = 1'b1;
        addr_c = alu_result;
        // read wins when both controls are set
        we_c   = should_write_mem & ~should_read_mem;
        if (mem_ready) state_d = S_WB;
      end
      S_WB: begin
        rwe_c        = should_write_reg;
        xwe_c        = should_write_xmm;
        pc_d         = pc_next;
        retire_cnt_d = retire_cnt_q + 32'd1;
        state_d      = halt_req ? S_HALT : S_FETCH;
        halted_d     = halt_req;
      end
      S_HALT: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      retire_cnt_q <= 32'd0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
      halted_q     <= halted_d;
    end
  end

  // strobes drop as soon as reset asserts, not at the next edge
  assign mem_req      = req_c & reset_n;
  assign mem_we       = we_c & reset_n;
  assign instr_we     = iwe_c & reset_n;
  assign reg_we       = rwe_c & reset_n;
  assign xmm_we       = xwe_c & reset_n;
  assign mem_addr     = addr_c;
  assign pc           = pc_q;
  assign state        = state_q;
  assign halted       = halted_q;
  assign retire_count = retire_cnt_q;

endmodule

// File: tb/tb_core_step_sequencer.sv
// Scoreboard bench for core_step_sequencer.
// Directed instructions; a negedge monitor pops expected memory/WB events.
module tb_core_step_sequencer;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        halt_req;
  logic        should_read_mem;
  logic        should_write_mem;
  logic        should_write_reg;
  logic        should_write_xmm;
  logic [31:0] alu_result;
  logic [31:0] pc_next;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        instr_we;
  logic        reg_we;
  logic        xmm_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] retire_count;

  core_step_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .run              (run),
    .halt_req         (halt_req),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .should_write_reg (should_write_reg),
    .should_write_xmm (should_write_xmm),
    .alu_result       (alu_result),
    .pc_next          (pc_next),
    .mem_ready        (mem_ready),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .instr_we         (instr_we),
    .reg_we           (reg_we),
    .xmm_we           (xmm_we),
    .pc               (pc),
    .state            (state),
    .halted           (halted),
    .retire_count     (retire_count)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic        iwe;
  } mexp_t;

  typedef struct packed {
    logic rwe;
    logic xwe;
  } wexp_t;

  mexp_t mem_q[$];
  wexp_t wb_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc_m;
  logic [31:0] cnt_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: pops expected memory handshakes and WB strobes
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", {mem_we, mem_addr, instr_we}, 64'h0);
        end else begin
          mexp_t e;
          e = mem_q.pop_front();
          chk("mem_txn", {mem_we, mem_addr, instr_we}, e);
        end
      end else if (state == 3'd3 && mem_req && mem_q.size() > 0) begin
        chk("mem_hold", {mem_we, mem_addr, instr_we}, mem_q[0]);
      end
      if (state == 3'd4) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", {reg_we, xmm_we}, 64'h0);
        end else begin
          wexp_t w;
          w = wb_q.pop_front();
          chk("wb_strobes", {reg_we, xmm_we}, w);
        end
      end else begin
        chk("idle_strobes", {reg_we, xmm_we}, 64'h0);
      end
    end
  end

  task automatic do_instr(
    input logic rd, input logic wr, input logic wreg, input logic wxmm,
    input logic [31:0] addr, input logic [31:0] nxt,
    input int fw, input int mw, input int hmode,
    input int ecyc, input logic [23:0] etrace);
    int          n;
    int          fl;
    int          ml;
    logic        done;
    logic [2:0]  s;
    logic [23:0] tr;
    mem_q.push_back('{we: 1'b0, addr: pc_m, iwe: 1'b1});
    if (rd | wr)
      mem_q.push_back('{we: wr & ~rd, addr: addr, iwe: 1'b0});
    wb_q.push_back('{rwe: wreg, xwe: wxmm});
    should_read_mem  = rd;
    should_write_mem = wr;
    should_write_reg = wreg;
    should_write_xmm = wxmm;
    alu_result       = addr;
    pc_next          = nxt;
    run              = 1'b1;
    n    = 0;
    fl   = fw;
    ml   = mw;
    done = 1'b0;
    tr   = '0;
    while (!done && n < 64) begin
      s  = state;
      tr = {tr[20:0], s};
      if (s == 3'd0) begin
        mem_ready = (fl == 0);
        if (fl > 0) fl--;
      end else if (s == 3'd3) begin
        mem_ready = (ml == 0);
        if (ml > 0) ml--;
      end else begin
        mem_ready = 1'b1;
      end
      if (s != 3'd0) run = 1'b0;
      halt_req = (hmode == 2) || (hmode == 1 && s == 3'd1);
      n++;
      @(posedge clk);
      #1;
      if (s == 3'd4) done = 1'b1;
    end
    halt_req  = 1'b0;
    mem_ready = 1'b0;
    run       = 1'b0;
    pc_m      = nxt;
    cnt_m     = cnt_m + 32'd1;
    chk("retired", done, 1);
    chk("cycles", n, ecyc);
    chk("trace", tr, etrace);
    chk("pc", pc, pc_m);
    chk("retire_count", retire_count, cnt_m);
    chk("end_state", state, (hmode == 2) ? 3'd5 : 3'd0);
    chk("halted", halted, (hmode == 2) ? 1 : 0);
  endtask

  initial begin
    reset_n          = 1'b0;
    run              = 1'b0;
    halt_req         = 1'b0;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
    should_write_reg = 1'b0;
    should_write_xmm = 1'b0;
    alu_result       = 32'h0;
    pc_next          = 32'h0;
    mem_ready        = 1'b1;
    pc_m             = 32'h0;
    cnt_m            = 32'h0;
    #3;
    chk("rst_strobes", {mem_req, mem_we, instr_we, reg_we, xmm_we}, 0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_state", state, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    chk("idle_req", mem_req, 0);
    chk("idle_state", state, 0);
    chk("idle_pc", pc, 32'h0);

    // ALU, store with 3 wait cycles, load, read+write with fetch waits
    do_instr(0, 0, 1, 0, 32'h0,   32'h4,  0, 0, 0, 4, 24'o00000124);
    do_instr(0, 1, 0, 0, 32'h100, 32'h8,  0, 3, 0, 8, 24'o01233334);
    do_instr(1, 0, 1, 0, 32'h200, 32'hC,  0, 0, 0, 5, 24'o00001234);
    do_instr(1, 1, 0, 1, 32'h300, 32'h10, 2, 0, 0, 7, 24'o00001234);
    // halt pulsed only in DECODE is ignored, held through WB halts
    do_instr(0, 0, 0, 1, 32'h0,   32'h14, 0, 0, 1, 4, 24'o00000124);
    do_instr(0, 0, 1, 0, 32'h0,   32'h18, 0, 0, 2, 4, 24'o00000124);

    run       = 1'b1;
    mem_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("halt_req_off", mem_req, 0);
      chk("halt_state", {state, halted}, {3'd5, 1'b1});
    end
    run       = 1'b0;
    mem_ready = 1'b0;

    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_from_halt", {state, halted}, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", retire_count, 32'h0);
    pc_m  = 32'h0;
    cnt_m = 32'h0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset while a store is waiting in MEM
    mem_q.push_back('{we: 1'b0, addr: 32'h0, iwe: 1'b1});
    mem_q.push_back('{we: 1'b1, addr: 32'h400, iwe: 1'b0});
    should_write_mem = 1'b1;
    alu_result       = 32'h400;
    run              = 1'b1;
    mem_ready        = 1'b1;
    @(posedge clk);
    #1;
    run       = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mem_pending", {state, mem_req, mem_we}, {3'd3, 2'b11});
    chk("mem_pending_addr", mem_addr, 32'h400);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_strobes", {mem_req, mem_we, instr_we}, 0);
    chk("async_state", state, 0);
    chk("async_addr", mem_addr, 32'h0);
    mem_q.delete();
    wb_q.delete();
    should_write_mem = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // counter wrap: preload the retire counter to all ones
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retire_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    do_instr(0, 0, 1, 0, 32'h0, 32'h20, 0, 0, 0, 4, 24'o00000124);
    chk("wrap_zero", retire_count, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("mem_q_empty", mem_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
